// File: rtl/iot_riscv_mdu_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide
// sequencing controller (slave).
interface iot_riscv_mdu_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic        req_a_signed_i;
  logic        req_b_signed_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic        kill_i;
  logic        res_valid_o;
  logic [31:0] res_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_op_i, req_a_signed_i, req_b_signed_i,
           req_a_i, req_b_i, kill_i,
    input  req_ready_o, res_valid_o, res_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_signed_i, req_b_signed_i,
           req_a_i, req_b_i, kill_i,
    output req_ready_o, res_valid_o, res_o, busy_o
  );
endinterface

// File: rtl/iot_riscv_mdu_ctrl.sv
// Multi-cycle M-extension sequencer: 32-step shift-add multiply / restoring
// divide on magnitudes, sign fix-up afterwards, one-entry result cache.
module iot_riscv_mdu_ctrl #(
  parameter bit early_out_p = 1'b1
) (
  input logic              clk_i,
  input logic              rst_an_i,
  iot_riscv_mdu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_res;
  logic        r_cvld;
  logic [31:0] r_ca, r_cb;
  logic        r_cas, r_cbs, r_cdiv;
  logic [63:0] r_cdata;

  logic        w_ready, w_accept, w_div, w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b;
  logic        w_hit, w_bzero, w_ovf, w_early, w_strobe;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next, w_div_next, w_fix;
  logic [32:0] w_part;
  logic        w_ge;
  logic [31:0] w_diff, w_quo_fix, w_rem_fix, w_sel;
  logic [63:0] w_prod_fix;

  assign w_ready  = (r_state == IDLE) && !bus.kill_i;
  assign w_accept = bus.req_valid_i && w_ready;
  assign w_div    = bus.req_op_i[1];
  assign w_sa     = bus.req_a_signed_i & bus.req_a_i[31];
  assign w_sb     = bus.req_b_signed_i & bus.req_b_i[31];
  assign w_abs_a  = w_sa ? -bus.req_a_i : bus.req_a_i;
  assign w_abs_b  = w_sb ? -bus.req_b_i : bus.req_b_i;
  assign w_bzero  = (bus.req_b_i == '0);
  assign w_ovf    = bus.req_a_signed_i && bus.req_b_signed_i &&
                    (bus.req_a_i == 32'h8000_0000) && (bus.req_b_i == '1);
  assign w_early  = early_out_p && w_div && (w_bzero || w_ovf);
  assign w_hit    = r_cvld && (bus.req_a_i == r_ca) && (bus.req_b_i == r_cb) &&
                    (bus.req_a_signed_i == r_cas) && (bus.req_b_signed_i == r_cbs) &&
                    (w_div == r_cdiv);

  // Multiply step: conditional add into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

  // Divide step: rem in acc[63:32], quotient shifting in from the bottom.
  // The partial remainder is kept 33 bits wide so divisors above 2^31 work.
  assign w_part     = {r_acc[63:32], r_acc[31]};
  assign w_ge       = (w_part >= {1'b0, r_b});
  assign w_diff     = w_part[31:0] - r_b;
  assign w_div_next = {w_ge ? w_diff : w_part[31:0], r_acc[30:0], w_ge};

  // Sign fix-up; a zero divisor never sets neg_q so the quotient stays all-ones.
  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
  assign w_fix      = r_op[1] ? {w_rem_fix, w_quo_fix} : w_prod_fix;

  // MUL/DIV read the low word, MULH/REM the high word.
  assign w_sel    = r_op[0] ? r_acc[63:32] : r_acc[31:0];
  assign w_strobe = (r_state == DONE) && !bus.kill_i;

  assign bus.req_ready_o = w_ready;
  assign bus.res_valid_o = w_strobe;
  assign bus.res_o       = w_strobe ? w_sel : r_res;
  assign bus.busy_o      = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state selection; kill forces IDLE from any state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (w_hit || w_early) ? DONE : CALC;
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.kill_i) w_next = IDLE;
  end

  // Operand capture, iteration datapath, cache and held result.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_cvld  <= 1'b0;
      r_ca    <= '0;
      r_cb    <= '0;
      r_cas   <= 1'b0;
      r_cbs   <= 1'b0;
      r_cdiv  <= 1'b0;
      r_cdata <= '0;
    end else begin
      if (bus.kill_i) r_cvld <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= bus.req_op_i;
          r_b     <= w_abs_b;
          r_neg_q <= (w_sa ^ w_sb) && !w_bzero;
          r_neg_r <= w_sa;
          r_cnt   <= 5'd31;
          if (w_hit) begin
            r_acc <= r_cdata;
          end else begin
            r_ca   <= bus.req_a_i;
            r_cb   <= bus.req_b_i;
            r_cas  <= bus.req_a_signed_i;
            r_cbs  <= bus.req_b_signed_i;
            r_cdiv <= w_div;
            r_cvld <= 1'b0;
            if (w_early)
              r_acc <= w_bzero ? {bus.req_a_i, 32'hFFFF_FFFF} : {32'h0, 32'h8000_0000};
            else
              r_acc <= {32'h0, w_abs_a};
          end
        end
        CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 5'd1;
        end
        FIX: begin
          r_acc <= w_fix;
          if (!bus.kill_i) begin
            r_cdata <= w_fix;
            r_cvld  <= 1'b1;
          end
        end
        DONE: if (!bus.kill_i) r_res <= w_sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iot_riscv_mdu_ctrl.sv
// Self-checking bench for iot_riscv_mdu_ctrl: reference results from plain
// wide signed arithmetic, cache/early-out latency from an abstract tag model.
module tb_iot_riscv_mdu_ctrl;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  iot_riscv_mdu_ctrl_if bus();

  iot_riscv_mdu_ctrl #(.early_out_p(1'b1)) dut (
    .clk_i   (clk),
    .rst_an_i(rst_an),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // expectation state written by the stimulus
  bit          active = 1'b0;
  bit          pending = 1'b0;
  int          due = -1;
  int          bfrom = 1, bto = 0;
  logic [31:0] exp_val = '0;
  bit          has_lit = 1'b0;
  logic [31:0] lit = '0;
  // written only by the compare process
  logic [31:0] last_res = '0;
  bit          ev, eb;

  // abstract cache model
  bit          mc_valid = 1'b0;
  logic [31:0] mc_a, mc_b;
  bit          mc_as, mc_bs, mc_div;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic as, input logic bs,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] xa, xb, p, q, r;
    xa = as ? {{34{a[31]}}, a} : {34'b0, a};
    xb = bs ? {{34{b[31]}}, b} : {34'b0, b};
    p  = xa * xb;
    if (op == 2'd0) return p[31:0];
    if (op == 2'd1) return p[63:32];
    if (b == 32'h0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    q = xa / xb;
    r = xa % xb;
    return (op == 2'd2) ? q[31:0] : r[31:0];
  endfunction

  // Compare process: every falling edge.
  always @(negedge clk) begin
    if (!rst_an) begin
      chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
      chk("rst_valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("rst_res",   bus.res_o, 32'd0);
      chk("rst_busy",  {31'b0, bus.busy_o}, 32'd0);
      last_res = '0;
    end else if (active) begin
      ev = pending && (cyc == due);
      eb = (cyc >= bfrom) && (cyc <= bto);
      chk("res_valid", {31'b0, bus.res_valid_o}, {31'b0, ev});
      chk("busy",      {31'b0, bus.busy_o}, {31'b0, eb});
      chk("ready",     {31'b0, bus.req_ready_o}, {31'b0, !eb && !bus.kill_i});
      if (ev) begin
        chk("result", bus.res_o, exp_val);
        if (has_lit) chk("result_literal", bus.res_o, lit);
        last_res = exp_val;
      end else begin
        chk("res_hold", bus.res_o, last_res);
      end
    end
  end

  task automatic scramble();
    bus.req_op_i       = 2'($urandom);
    bus.req_a_signed_i = 1'($urandom);
    bus.req_b_signed_i = 1'($urandom);
    bus.req_a_i        = $urandom;
    bus.req_b_i        = $urandom;
  endtask

  // Issue one operation from an idle cycle (called at posedge+1).
  // abort_at: cycle offset after accept for kill (or reset if use_rst), 0 = none.
  task automatic do_op(input logic [1:0] op, input logic as, input logic bs,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit hl, input logic [31:0] l, input int lit_lat,
                       input int abort_at, input bit use_rst);
    bit hit, early;
    int lat;
    hit   = mc_valid && mc_a == a && mc_b == b && mc_as == as && mc_bs == bs && mc_div == op[1];
    early = op[1] && (b == 32'h0 || (as && bs && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    if (hit) lat = 1;
    else begin
      mc_a = a; mc_b = b; mc_as = as; mc_bs = bs; mc_div = op[1];
      mc_valid = !early;
      lat = early ? 1 : 34;
    end
    if (lit_lat != 0) chk("latency_model", lat, lit_lat);
    bus.req_valid_i = 1'b1;
    bus.req_op_i = op; bus.req_a_signed_i = as; bus.req_b_signed_i = bs;
    bus.req_a_i = a; bus.req_b_i = b;
    exp_val = ref_res(op, as, bs, a, b);
    has_lit = hl; lit = l;
    due = cyc + lat; bfrom = cyc + 1; bto = cyc + lat; pending = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    scramble();
    for (int i = 1; i <= lat; i++) begin
      if (i == abort_at) begin
        pending = 1'b0; mc_valid = 1'b0;
        if (use_rst) begin
          rst_an = 1'b0; bus.req_valid_i = 1'b1;
          bfrom = 1; bto = 0;
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst_an = 1'b1; bus.req_valid_i = 1'b0;
        end else begin
          bus.kill_i = 1'b1; bto = cyc;
          @(posedge clk); #1;
          bus.kill_i = 1'b0;
        end
        break;
      end
      @(posedge clk); #1;
    end
    pending = 1'b0;
  endtask

  // Request raised together with kill in an idle cycle: must not be accepted.
  task automatic kill_req();
    scramble();
    bus.req_valid_i = 1'b1; bus.kill_i = 1'b1; mc_valid = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; bus.kill_i = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic        ras, rbs;
    int          ab;
    bus.req_valid_i = 1'b0; bus.kill_i = 1'b0;
    bus.req_op_i = '0; bus.req_a_signed_i = 1'b0; bus.req_b_signed_i = 1'b0;
    bus.req_a_i = '0; bus.req_b_i = '0;
    repeat (3) @(posedge clk);
    #1; rst_an = 1'b1; active = 1'b1;

    do_op(2'd0, 1, 1, 32'd7,         32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 34, 0, 0);
    do_op(2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 34, 0, 0);
    do_op(2'd1, 1, 1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 34, 0, 0);
    do_op(2'd2, 1, 1, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 34, 0, 0);
    do_op(2'd3, 1, 1, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 1,  0, 0);
    do_op(2'd2, 0, 0, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 1,  0, 0);
    do_op(2'd3, 0, 0, 32'd5,         32'd0,         1, 32'd5,         1,  0, 0);
    do_op(2'd2, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1,  0, 0);
    do_op(2'd3, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         1,  0, 0);
    // kill mid-CALC, then the partner op must recompute
    do_op(2'd2, 0, 0, 32'd1234567,   32'd89,        0, 32'd0,         34, 10, 0);
    do_op(2'd3, 0, 0, 32'd1234567,   32'd89,        1, 32'd48,        34, 0, 0);
    // reset mid-CALC with a request held high
    do_op(2'd2, 1, 0, 32'hDEAD_BEEF, 32'd1000,      0, 32'd0,         34, 15, 1);
    kill_req();
    // MUL/MULH pair hit, then a hit killed in DONE
    do_op(2'd0, 1, 0, 32'hFFFF_FF00, 32'h1234_5678, 0, 32'd0,         34, 0, 0);
    do_op(2'd1, 1, 0, 32'hFFFF_FF00, 32'h1234_5678, 0, 32'd0,         1,  0, 0);
    do_op(2'd0, 1, 0, 32'hFFFF_FF00, 32'h1234_5678, 0, 32'd0,         1,  1, 0);
    do_op(2'd1, 1, 0, 32'hFFFF_FF00, 32'h1234_5678, 0, 32'd0,         34, 0, 0);

    ra = '0; rb = '0; ras = 0; rbs = 0;
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom);
      if ($urandom_range(0, 9) >= 3) begin
        ra = pick(); rb = pick();
        ras = 1'($urandom); rbs = 1'($urandom);
      end
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 34) : 0;
      do_op(rop, ras, rbs, ra, rb, 0, 32'd0, 0, ab, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 19) == 0) kill_req();
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: got no completion, expected finish within bound");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
